// File: rtl/arena_grid_mem_pkg.sv
// ----------------------------------------------------------------------------
// arena_pkg
// Shared definitions for the light-cycle arena cell store: grid geometry,
// cell encodings, coordinate types, controller state enum and the helper
// that turns a cell coordinate into a row-major RAM address.
// Used by: arena_grid_mem_if, arena_grid_ram, arena_grid_mem.
// ----------------------------------------------------------------------------
package arena_pkg;

    localparam int GRID_W     = 80;
    localparam int GRID_H     = 60;
    localparam int CELL_PX    = 8;
    localparam int CELL_SHIFT = 3;
    localparam int BORDER     = 2;
    localparam int CELLS      = GRID_W * GRID_H;
    localparam int ADDR_W     = 13;

    localparam logic [1:0] CELL_EMPTY  = 2'd0;
    localparam logic [1:0] CELL_TRAIL1 = 2'd1;
    localparam logic [1:0] CELL_WALL   = 2'd2;
    localparam logic [1:0] CELL_TRAIL2 = 2'd3;

    typedef logic [6:0]        cell_x_t;
    typedef logic [5:0]        cell_y_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Row-major address of a cell that is already known to be in range.
    function automatic addr_t cell_addr(input cell_x_t cx, input cell_y_t cy);
        return addr_t'(cx) + addr_t'(cy) * addr_t'(GRID_W);
    endfunction

endpackage

// File: rtl/arena_grid_mem_if.sv
// ----------------------------------------------------------------------------
// arena_grid_mem_if
// Port B request bus of the arena store: trail writes and collision queries
// from the player movement stages.
//   master : the requester (drives wr_*/q_* requests, receives acks/results)
//   slave  : the arena store
// ----------------------------------------------------------------------------
interface arena_grid_mem_if;
    import arena_pkg::*;

    logic       wr_req;
    cell_x_t    wr_cx;
    cell_y_t    wr_cy;
    logic [1:0] wr_val;
    logic       wr_ack;

    logic       q_req;
    cell_x_t    q_cx;
    cell_y_t    q_cy;
    logic       q_ack;
    logic [1:0] q_cell;
    logic       q_hit;

    modport master (
        output wr_req, wr_cx, wr_cy, wr_val,
        input  wr_ack,
        output q_req, q_cx, q_cy,
        input  q_ack, q_cell, q_hit
    );

    modport slave (
        input  wr_req, wr_cx, wr_cy, wr_val,
        output wr_ack,
        input  q_req, q_cx, q_cy,
        output q_ack, q_cell, q_hit
    );

endinterface

// File: rtl/arena_grid_ram.sv
// ----------------------------------------------------------------------------
// arena_grid_ram
// Simple dual-port CELLS x 2-bit RAM, synchronous read on both ports.
//   clk     : clock
//   a_addr  : port A (read-only) address,  a_dout : port A read data
//   b_addr  : port B address, b_we/b_wdata : port B write,
//   b_dout  : port B read data
// A read on either port that hits the cell being written returns the old value.
// ----------------------------------------------------------------------------
module arena_grid_ram
    import arena_pkg::*;
(
    input  logic       clk,
    input  addr_t      a_addr,
    output logic [1:0] a_dout,
    input  addr_t      b_addr,
    input  logic       b_we,
    input  logic [1:0] b_wdata,
    output logic [1:0] b_dout
);

    logic [1:0] mem [0:CELLS-1];

    // Both ports register their read data from the array contents before this
    // edge's write lands, which gives read-old-value behaviour on collisions.
    always_ff @(posedge clk) begin
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
        b_dout <= mem[b_addr];
        a_dout <= mem[a_addr];
    end

endmodule

// File: rtl/arena_grid_mem.sv
// ----------------------------------------------------------------------------
// arena_grid_mem
// Shared 80x60 arena cell store. Sweeps the grid on reset/restart (walls on
// the border, empty inside), then serves one port B request per cycle with
// write priority over query, while port A serves the VGA compositor.
//   CLOCK_50  : clock            reset_n  : async active-low reset
//   reiniciar : restart request  busy     : clear sweep running
//   rd_x/rd_y : VGA pixel coords rd_cell  : cell under pixel (1-cycle latency)
//   port_b    : arena_grid_mem_if.slave (writes and collision queries)
//   trail_cnt : non-empty cells gained since last clear (option only)
// Option ARENA_OCCUPANCY_COUNT_EN: adds trail_cnt; writes become 2-cycle
// read-then-write so the old cell value is known.
// ----------------------------------------------------------------------------
module arena_grid_mem
    import arena_pkg::*;
(
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              reiniciar,
    output logic              busy,
    input  logic [9:0]        rd_x,
    input  logic [9:0]        rd_y,
    output logic [1:0]        rd_cell,
    arena_grid_mem_if.slave   port_b
`ifdef ARENA_OCCUPANCY_COUNT_EN
    ,
    output logic [12:0]       trail_cnt
`endif
);

    state_t     state, state_n;
    addr_t      idx, idx_n;
    cell_x_t    x_cnt, x_n;
    cell_y_t    y_cnt, y_n;
    logic       busy_r, busy_n;
    logic       wr_ack_r, wr_ack_n;
    logic       q_ack_r, q_ack_n;
    logic       q_oor, q_oor_n;
    logic [1:0] q_hold;
    logic       rd_valid;

    addr_t      ram_a_addr, ram_b_addr;
    logic       ram_we;
    logic [1:0] ram_wdata, ram_a_dout, ram_b_dout;

    logic       w_inr, q_inr, a_inr;
    addr_t      w_addr, q_addr;
    logic [1:0] q_cell_out;

`ifdef ARENA_OCCUPANCY_COUNT_EN
    logic       wr_phase, wr_phase_n;
    addr_t      wr_addr_r, wr_addr_n;
    logic [1:0] wr_val_r, wr_val_n;
    logic       wr_inr_r, wr_inr_n;
    logic [12:0] cnt_r, cnt_n;
`endif

    arena_grid_ram u_ram (
        .clk     (CLOCK_50),
        .a_addr  (ram_a_addr),
        .a_dout  (ram_a_dout),
        .b_addr  (ram_b_addr),
        .b_we    (ram_we),
        .b_wdata (ram_wdata),
        .b_dout  (ram_b_dout)
    );

    // Range checks and addresses for both ports; out-of-range coordinates are
    // steered to address 0 so the RAM is never indexed past its end.
    always_comb begin
        w_inr      = (port_b.wr_cx < cell_x_t'(GRID_W)) && (port_b.wr_cy < cell_y_t'(GRID_H));
        q_inr      = (port_b.q_cx  < cell_x_t'(GRID_W)) && (port_b.q_cy  < cell_y_t'(GRID_H));
        w_addr     = w_inr ? cell_addr(port_b.wr_cx, port_b.wr_cy) : '0;
        q_addr     = q_inr ? cell_addr(port_b.q_cx,  port_b.q_cy)  : '0;
        a_inr      = (rd_x < 10'(GRID_W * CELL_PX)) && (rd_y < 10'(GRID_H * CELL_PX));
        ram_a_addr = a_inr ? cell_addr(7'(rd_x >> CELL_SHIFT), 6'(rd_y >> CELL_SHIFT)) : '0;
    end

    // Next-state logic: restart overrides everything; CLEAR writes one cell
    // per cycle walking row-major with x/y counters for the border test; RUN
    // serves writes ahead of queries, one per cycle.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        x_n       = x_cnt;
        y_n       = y_cnt;
        busy_n    = busy_r;
        wr_ack_n  = 1'b0;
        q_ack_n   = 1'b0;
        q_oor_n   = q_oor;
        ram_we    = 1'b0;
        ram_b_addr = '0;
        ram_wdata = CELL_EMPTY;
`ifdef ARENA_OCCUPANCY_COUNT_EN
        wr_phase_n = 1'b0;
        wr_addr_n  = wr_addr_r;
        wr_val_n   = wr_val_r;
        wr_inr_n   = wr_inr_r;
        cnt_n      = cnt_r;
`endif
        if (reiniciar) begin
            state_n = CLEAR;
            idx_n   = '0;
            x_n     = '0;
            y_n     = '0;
            busy_n  = 1'b1;
`ifdef ARENA_OCCUPANCY_COUNT_EN
            cnt_n   = '0;
`endif
        end else begin
            case (state)
                CLEAR: begin
                    ram_we     = 1'b1;
                    ram_b_addr = idx;
                    if ((x_cnt < cell_x_t'(BORDER)) || (x_cnt >= cell_x_t'(GRID_W - BORDER)) ||
                        (y_cnt < cell_y_t'(BORDER)) || (y_cnt >= cell_y_t'(GRID_H - BORDER))) begin
                        ram_wdata = CELL_WALL;
                    end
`ifdef ARENA_OCCUPANCY_COUNT_EN
                    cnt_n = '0;
`endif
                    if (idx == addr_t'(CELLS - 1)) begin
                        state_n = RUN;
                        busy_n  = 1'b0;
                        idx_n   = '0;
                        x_n     = '0;
                        y_n     = '0;
                    end else begin
                        idx_n = idx + 1'b1;
                        if (x_cnt == cell_x_t'(GRID_W - 1)) begin
                            x_n = '0;
                            y_n = y_cnt + 1'b1;
                        end else begin
                            x_n = x_cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
`ifdef ARENA_OCCUPANCY_COUNT_EN
                    if (wr_phase) begin
                        // Second write cycle: old value is on ram_b_dout now.
                        wr_ack_n = 1'b1;
                        if (wr_inr_r) begin
                            ram_we     = 1'b1;
                            ram_b_addr = wr_addr_r;
                            ram_wdata  = wr_val_r;
                            if ((ram_b_dout == CELL_EMPTY) && (wr_val_r != CELL_EMPTY)) begin
                                cnt_n = cnt_r + 1'b1;
                            end else if ((ram_b_dout != CELL_EMPTY) && (wr_val_r == CELL_EMPTY)) begin
                                cnt_n = cnt_r - 1'b1;
                            end
                        end
                    end else if (port_b.wr_req) begin
                        wr_phase_n = 1'b1;
                        wr_addr_n  = w_addr;
                        wr_val_n   = port_b.wr_val;
                        wr_inr_n   = w_inr;
                        ram_b_addr = w_addr;
                    end else if (port_b.q_req) begin
                        q_ack_n    = 1'b1;
                        q_oor_n    = ~q_inr;
                        ram_b_addr = q_addr;
                    end
`else
                    if (port_b.wr_req) begin
                        wr_ack_n   = 1'b1;
                        ram_we     = w_inr;
                        ram_b_addr = w_addr;
                        ram_wdata  = port_b.wr_val;
                    end else if (port_b.q_req) begin
                        q_ack_n    = 1'b1;
                        q_oor_n    = ~q_inr;
                        ram_b_addr = q_addr;
                    end
`endif
                end
                default: begin
                    state_n = CLEAR;
                end
            endcase
        end
    end

    // State and handshake registers. q_hold keeps the last query result so
    // q_cell stays stable between acks even though the RAM read port moves on.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= CLEAR;
            idx      <= '0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            busy_r   <= 1'b1;
            wr_ack_r <= 1'b0;
            q_ack_r  <= 1'b0;
            q_oor    <= 1'b0;
            q_hold   <= CELL_EMPTY;
            rd_valid <= 1'b0;
`ifdef ARENA_OCCUPANCY_COUNT_EN
            wr_phase  <= 1'b0;
            wr_addr_r <= '0;
            wr_val_r  <= CELL_EMPTY;
            wr_inr_r  <= 1'b0;
            cnt_r     <= '0;
`endif
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            x_cnt    <= x_n;
            y_cnt    <= y_n;
            busy_r   <= busy_n;
            wr_ack_r <= wr_ack_n;
            q_ack_r  <= q_ack_n;
            q_oor    <= q_oor_n;
            q_hold   <= q_cell_out;
            rd_valid <= a_inr & ~busy_r;
`ifdef ARENA_OCCUPANCY_COUNT_EN
            wr_phase  <= wr_phase_n;
            wr_addr_r <= wr_addr_n;
            wr_val_r  <= wr_val_n;
            wr_inr_r  <= wr_inr_n;
            cnt_r     <= cnt_n;
`endif
        end
    end

    // Query result: fresh RAM data (or wall for out-of-range) in the ack
    // cycle, otherwise the held copy.
    always_comb begin
        if (q_ack_r) begin
            q_cell_out = q_oor ? CELL_WALL : ram_b_dout;
        end else begin
            q_cell_out = q_hold;
        end
    end

    assign busy          = busy_r;
    assign rd_cell       = rd_valid ? ram_a_dout : CELL_EMPTY;
    assign port_b.wr_ack = wr_ack_r;
    assign port_b.q_ack  = q_ack_r;
    assign port_b.q_cell = q_cell_out;
    assign port_b.q_hit  = (q_cell_out != CELL_EMPTY);
`ifdef ARENA_OCCUPANCY_COUNT_EN
    assign trail_cnt     = cnt_r;
`endif

endmodule

// File: tb/tb_arena_grid_mem.sv
// ----------------------------------------------------------------------------
// tb_arena_grid_mem
// Self-checking bench for arena_grid_mem: directed scenarios plus randomized
// writes/queries/VGA reads compared against a plain array model of the arena.
// ----------------------------------------------------------------------------
module tb_arena_grid_mem;
    import arena_pkg::*;

`ifdef ARENA_OCCUPANCY_COUNT_EN
    localparam int WR_LAT = 2;
`else
    localparam int WR_LAT = 1;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       reset_n = 1'b0;
    logic       reiniciar = 1'b0;
    logic       busy;
    logic [9:0] rd_x = '0;
    logic [9:0] rd_y = '0;
    logic [1:0] rd_cell;
`ifdef ARENA_OCCUPANCY_COUNT_EN
    logic [12:0] trail_cnt;
`endif

    arena_grid_mem_if bus ();

    arena_grid_mem dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .reiniciar (reiniciar),
        .busy      (busy),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_cell   (rd_cell),
        .port_b    (bus.slave)
`ifdef ARENA_OCCUPANCY_COUNT_EN
        ,
        .trail_cnt (trail_cnt)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int         compared = 0;
    int         mismatched = 0;
    logic [1:0] model [0:GRID_W*GRID_H-1];
    int         base_walls;
    bit         arena_ready = 1'b0;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Arena contents right after a sweep: two-cell wall frame, empty inside.
    task automatic resetModel();
        base_walls = 0;
        for (int y = 0; y < GRID_H; y++) begin
            for (int x = 0; x < GRID_W; x++) begin
                if (x < 2 || x > GRID_W - 3 || y < 2 || y > GRID_H - 3) begin
                    model[y*GRID_W + x] = 2'd2;
                    base_walls++;
                end else begin
                    model[y*GRID_W + x] = 2'd0;
                end
            end
        end
    endtask

    function automatic int modelTrail();
        int n = 0;
        for (int i = 0; i < GRID_W*GRID_H; i++) begin
            if (model[i] != 2'd0) n++;
        end
        return (n - base_walls) & 32'h1FFF;
    endfunction

    function automatic int expectQuery(input int x, input int y);
        if (x >= GRID_W || y >= GRID_H) return 2;
        return int'(model[y*GRID_W + x]);
    endfunction

    // Counts edges until busy drops; caller is at a negedge with busy high.
    task automatic waitClear(input string tag, input int exp);
        int cnt = 0;
        while (busy === 1'b1 && cnt < 6000) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            cnt++;
        end
        checkOutput(tag, cnt, exp);
        arena_ready = 1'b1;
    endtask

    task automatic pulseRestart(input string tag);
        reiniciar = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reiniciar = 1'b0;
        arena_ready = 1'b0;
        resetModel();
        checkOutput(tag, int'(busy), 1);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
        end
    endtask

    task automatic vgaRead(input int x, input int y, input string tag);
        int exp;
        rd_x = 10'(x);
        rd_y = 10'(y);
        if (!arena_ready || x >= GRID_W*CELL_PX || y >= GRID_H*CELL_PX) exp = 0;
        else exp = int'(model[(y/CELL_PX)*GRID_W + x/CELL_PX]);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        checkOutput(tag, int'(rd_cell), exp);
    endtask

    // One port B transaction (write, query, or both raised together).
    task automatic applyStimulus(input bit do_wr, input int wcx, input int wcy, input int wval,
                                 input bit do_q, input int qcx, input int qcy, input string tag);
        int         wcyc = -1;
        int         qcyc = -1;
        int         qexp;
        logic [1:0] qgot = 2'd0;
        logic       qhit = 1'b0;
        if (do_wr && wcx < GRID_W && wcy < GRID_H) model[wcy*GRID_W + wcx] = 2'(wval);
        qexp = expectQuery(qcx, qcy);
        bus.wr_req = do_wr;
        bus.wr_cx  = 7'(wcx);
        bus.wr_cy  = 6'(wcy);
        bus.wr_val = 2'(wval);
        bus.q_req  = do_q;
        bus.q_cx   = 7'(qcx);
        bus.q_cy   = 6'(qcy);
        for (int c = 1; c <= 12; c++) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            if (bus.wr_ack && wcyc < 0) begin
                wcyc = c;
                bus.wr_req = 1'b0;
            end
            if (bus.q_ack && qcyc < 0) begin
                qcyc = c;
                qgot = bus.q_cell;
                qhit = bus.q_hit;
                bus.q_req = 1'b0;
            end
            if ((wcyc >= 0 || !do_wr) && (qcyc >= 0 || !do_q)) break;
        end
        bus.wr_req = 1'b0;
        bus.q_req  = 1'b0;
        if (do_wr) checkOutput({tag, "_wr_lat"}, wcyc, WR_LAT);
        if (do_q) begin
            checkOutput({tag, "_q_lat"}, qcyc, do_wr ? WR_LAT + 1 : 1);
            checkOutput({tag, "_q_cell"}, int'(qgot), qexp);
            checkOutput({tag, "_q_hit"}, int'(qhit), (qexp != 0) ? 1 : 0);
        end
    endtask

    initial begin
        int c;
        bus.wr_req = 1'b0;
        bus.wr_cx  = '0;
        bus.wr_cy  = '0;
        bus.wr_val = '0;
        bus.q_req  = 1'b0;
        bus.q_cx   = '0;
        bus.q_cy   = '0;

        $display("[TB] reset and initial sweep");
        repeat (3) @(negedge CLOCK_50);
        checkOutput("rst_busy", int'(busy), 1);
        checkOutput("rst_rd_cell", int'(rd_cell), 0);
        checkOutput("rst_wr_ack", int'(bus.wr_ack), 0);
        checkOutput("rst_q_ack", int'(bus.q_ack), 0);
        checkOutput("rst_q_cell", int'(bus.q_cell), 0);
        checkOutput("rst_q_hit", int'(bus.q_hit), 0);
        resetModel();
        reset_n = 1'b1;
        waitClear("clear_len", 4800);

        applyStimulus(0, 0, 0, 0, 1, 0, 0, "q_corner");
        applyStimulus(0, 0, 0, 0, 1, 2, 2, "q_inner");
        applyStimulus(0, 0, 0, 0, 1, 77, 57, "q_far_inner");

        $display("[TB] single write, query, VGA read");
        applyStimulus(1, 10, 10, 1, 0, 0, 0, "wr_10_10");
        applyStimulus(0, 0, 0, 0, 1, 10, 10, "q_10_10");
        idleCycles(3);
        checkOutput("q_cell_held", int'(bus.q_cell), 1);
        vgaRead(80, 80, "vga_10_10");

        $display("[TB] write and query together");
        applyStimulus(1, 20, 5, 3, 1, 20, 5, "wq_20_5");

        $display("[TB] out of range");
        applyStimulus(0, 0, 0, 0, 1, 80, 0, "q_oor_x");
        applyStimulus(0, 0, 0, 0, 1, 0, 60, "q_oor_y");
        applyStimulus(1, 90, 3, 1, 0, 0, 0, "wr_oor");
        applyStimulus(0, 0, 0, 0, 1, 10, 3, "q_10_3");
        applyStimulus(0, 0, 0, 0, 1, 10, 4, "q_10_4");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 60; i++) begin
            int kind = $urandom_range(0, 2);
            int wx   = $urandom_range(0, 95);
            int wy   = $urandom_range(0, 63);
            int wv   = $urandom_range(0, 3);
            int qx   = (kind == 2 && $urandom_range(0, 1) == 1) ? wx : $urandom_range(0, 95);
            int qy   = (kind == 2 && $urandom_range(0, 1) == 1) ? wy : $urandom_range(0, 63);
            applyStimulus(kind != 1, wx, wy, wv, kind != 0, qx, qy, $sformatf("rnd%0d", i));
        end
        for (int i = 0; i < 20; i++) begin
            vgaRead($urandom_range(0, 700), $urandom_range(0, 520), $sformatf("vga_rnd%0d", i));
        end
`ifdef ARENA_OCCUPANCY_COUNT_EN
        checkOutput("trail_cnt_run", int'(trail_cnt), modelTrail());
`endif

        $display("[TB] restart in RUN and mid-sweep");
        pulseRestart("restart1_busy");
        vgaRead(80, 80, "vga_busy");
        waitClear("restart1_len", 4799);
        applyStimulus(0, 0, 0, 0, 1, 10, 10, "q_after_restart");
`ifdef ARENA_OCCUPANCY_COUNT_EN
        checkOutput("trail_cnt_clear", int'(trail_cnt), modelTrail());
`endif
        pulseRestart("restart2_busy");
        idleCycles(999);
        pulseRestart("restart3_busy");
        waitClear("restart3_len", 4800);

        $display("[TB] reset during sweep with pending query");
        pulseRestart("restart4_busy");
        idleCycles(500);
        bus.q_cx  = 7'd0;
        bus.q_cy  = 6'd0;
        bus.q_req = 1'b1;
        idleCycles(2);
        #3 reset_n = 1'b0;
        #1;
        checkOutput("rst2_busy", int'(busy), 1);
        checkOutput("rst2_q_ack", int'(bus.q_ack), 0);
        checkOutput("rst2_q_cell", int'(bus.q_cell), 0);
        checkOutput("rst2_rd_cell", int'(rd_cell), 0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        resetModel();
        c = 0;
        while (c < 6000) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            c++;
            if (bus.q_ack) break;
        end
        checkOutput("pend_q_lat", c, 4801);
        checkOutput("pend_q_busy", int'(busy), 0);
        checkOutput("pend_q_cell", int'(bus.q_cell), 2);
        checkOutput("pend_q_hit", int'(bus.q_hit), 1);
        bus.q_req = 1'b0;
        idleCycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
